// File: rtl/lsu_pkg.sv
// Shared types and helpers for the load/store unit: FSM states, dm_ctrl
// encodings (RISC-V funct3), access-size decode and byte-enable generation.
package lsu_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_REQ,
    ST_WAIT,
    ST_DONE
  } lsu_state_e;

  typedef enum logic [1:0] {
    SZ_B,
    SZ_H,
    SZ_W
  } lsu_size_e;

  localparam logic [2:0] DM_B  = 3'b000;
  localparam logic [2:0] DM_H  = 3'b001;
  localparam logic [2:0] DM_W  = 3'b010;
  localparam logic [2:0] DM_BU = 3'b100;
  localparam logic [2:0] DM_HU = 3'b101;

  // Reserved encodings (011, 110, 111) fall into the word case.
  function automatic lsu_size_e ctrl_size(input logic [2:0] ctrl);
    case (ctrl)
      DM_B, DM_BU: ctrl_size = SZ_B;
      DM_H, DM_HU: ctrl_size = SZ_H;
      default:     ctrl_size = SZ_W;
    endcase
  endfunction

  function automatic logic [3:0] byte_en(input logic [2:0] ctrl, input logic [1:0] off);
    case (ctrl_size(ctrl))
      SZ_B:    byte_en = 4'b0001 << off;
      SZ_H:    byte_en = 4'b0011 << off;
      default: byte_en = 4'b1111;
    endcase
  endfunction

  function automatic logic is_misaligned(input logic [2:0] ctrl, input logic [1:0] off);
    case (ctrl_size(ctrl))
      SZ_B:    is_misaligned = 1'b0;
      SZ_H:    is_misaligned = off[0];
      default: is_misaligned = (off != 2'b00);
    endcase
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Lane logic: replicates store data across byte lanes and extracts/extends
// the addressed byte or half of a loaded word.
module lsu_align
  import lsu_pkg::*;
(
  input  logic [2:0]  ctrl,
  input  logic [1:0]  off,
  input  logic [31:0] st_data,
  input  logic [31:0] ld_word,
  output logic [31:0] st_lanes,
  output logic [31:0] ld_data
);

  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic        sign_ext;

  // Halves are only ever taken from aligned offsets, so off[1] picks the lane.
  assign ld_byte  = ld_word[{off, 3'b000} +: 8];
  assign ld_half  = ld_word[{off[1], 4'b0000} +: 16];
  assign sign_ext = ~ctrl[2];

  // NOTE: every output gets a default before the case so no latch is inferred.
  always_comb begin
    st_lanes = st_data;
    ld_data  = ld_word;
    case (ctrl_size(ctrl))
      SZ_B: begin
        st_lanes = {4{st_data[7:0]}};
        ld_data  = {{24{sign_ext & ld_byte[7]}}, ld_byte};
      end
      SZ_H: begin
        st_lanes = {2{st_data[15:0]}};
        ld_data  = {{16{sign_ext & ld_half[15]}}, ld_half};
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/lsu_ctrl.sv
// Load/store controller: issues one handshaked memory access per load/store,
// stalls the core until it completes, flags misalignment and bus timeouts.
module lsu_ctrl
  import lsu_pkg::*;
#(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  input  logic        dm_wr,
  input  logic [2:0]  dm_ctrl,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        stall,
  output logic [31:0] rdata,
  output logic        misaligned,
  output logic        bus_err,
  output logic        mem_req,
  output logic        mem_we,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_gnt,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata
);

  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

  lsu_state_e  state_q, state_d;
  logic        wr_q, wr_d;
  logic [2:0]  ctrl_q, ctrl_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;
  logic [7:0]  cnt_q, cnt_d;

  logic        misalign_hit;
  logic        timeout_hit;
  logic [2:0]  align_ctrl;
  logic [1:0]  align_off;
  logic [31:0] st_lanes;
  logic [31:0] ld_data;

  // Store lanes come from the live inputs while idle; load extraction uses
  // the registered access once the request is in flight.
  assign align_ctrl = (state_q == ST_IDLE) ? dm_ctrl : ctrl_q;
  assign align_off  = (state_q == ST_IDLE) ? addr[1:0] : addr_q[1:0];

  lsu_align u_align (
    .ctrl     (align_ctrl),
    .off      (align_off),
    .st_data  (wdata),
    .ld_word  (mem_rdata),
    .st_lanes (st_lanes),
    .ld_data  (ld_data)
  );

  assign misalign_hit = is_misaligned(dm_ctrl, addr[1:0]);
  assign misaligned   = req_valid & misalign_hit & (state_q == ST_IDLE);
  assign stall        = req_valid & ~misaligned & (state_q != ST_DONE);
  assign timeout_hit  = (cnt_q == CNT_LAST);

  always_comb begin
    state_d = state_q;
    wr_d    = wr_q;
    ctrl_d  = ctrl_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    cnt_d   = cnt_q;
    err_d   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (req_valid && !misalign_hit) begin
          state_d = ST_REQ;
          wr_d    = dm_wr;
          ctrl_d  = dm_ctrl;
          addr_d  = addr;
          wdata_d = st_lanes;
          rdata_d = '0;
          cnt_d   = '0;
        end
      end
      ST_REQ: begin
        cnt_d = cnt_q + 8'd1;
        if (mem_gnt) begin
          state_d = wr_q ? ST_DONE : ST_WAIT;
        end else if (timeout_hit) begin
          state_d = ST_DONE;
          err_d   = 1'b1;
          rdata_d = '0;
        end
      end
      ST_WAIT: begin
        cnt_d = cnt_q + 8'd1;
        if (mem_rvalid) begin
          state_d = ST_DONE;
          rdata_d = ld_data;
        end else if (timeout_hit) begin
          state_d = ST_DONE;
          err_d   = 1'b1;
          rdata_d = '0;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      wr_q    <= 1'b0;
      ctrl_q  <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      wr_q    <= wr_d;
      ctrl_q  <= ctrl_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

  // Bus outputs are quiet outside REQ so the memory sees a clean request.
  assign mem_req   = (state_q == ST_REQ);
  assign mem_we    = mem_req & wr_q;
  assign mem_be    = mem_req ? byte_en(ctrl_q, addr_q[1:0]) : 4'b0000;
  assign mem_addr  = mem_req ? {addr_q[31:2], 2'b00} : 32'h0;
  assign mem_wdata = (mem_req && wr_q) ? wdata_q : 32'h0;
  assign rdata     = (state_q == ST_DONE) ? rdata_q : 32'h0;
  assign bus_err   = err_q;

endmodule

// File: tb/tb_lsu_ctrl.sv
// Self-checking bench for lsu_ctrl: directed vector table, randomized accesses
// against an arithmetic reference model, and reset/late-rvalid sequences.
module tb_lsu_ctrl;

  localparam int TIMEOUT = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        dm_wr;
  logic [2:0]  dm_ctrl;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        stall;
  logic [31:0] rdata;
  logic        misaligned;
  logic        bus_err;
  logic        mem_req;
  logic        mem_we;
  logic [3:0]  mem_be;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_gnt;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;

  int n_total = 0;
  int n_pass  = 0;

  always #5 clk = ~clk;

  lsu_ctrl #(.TIMEOUT(TIMEOUT)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .dm_wr      (dm_wr),
    .dm_ctrl    (dm_ctrl),
    .addr       (addr),
    .wdata      (wdata),
    .stall      (stall),
    .rdata      (rdata),
    .misaligned (misaligned),
    .bus_err    (bus_err),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .mem_be     (mem_be),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_gnt    (mem_gnt),
    .mem_rvalid (mem_rvalid),
    .mem_rdata  (mem_rdata)
  );

  typedef struct {
    logic        wr;
    logic [2:0]  ctrl;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rword;
    int          gnt_lat;
    int          rv_lat;
    logic        exp_mis;
    logic [3:0]  exp_be;
    logic [31:0] exp_maddr;
    logic [31:0] exp_mwdata;
    logic [31:0] exp_rdata;
    int          exp_stall;
    logic        exp_err;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
  endtask

  // Hand-written record: inputs plus expected results written out explicitly.
  function automatic vec_t tv(input logic wr, input logic [2:0] ctrl, input logic [31:0] a,
                              input logic [31:0] wd, input logic [31:0] rw, input int gl,
                              input int rl, input logic mis, input logic [3:0] be,
                              input logic [31:0] ma, input logic [31:0] mwd,
                              input logic [31:0] rd, input int st, input logic err);
    vec_t v;
    v.wr = wr; v.ctrl = ctrl; v.addr = a; v.wdata = wd; v.rword = rw;
    v.gnt_lat = gl; v.rv_lat = rl; v.exp_mis = mis; v.exp_be = be;
    v.exp_maddr = ma; v.exp_mwdata = mwd; v.exp_rdata = rd;
    v.exp_stall = st; v.exp_err = err;
    return v;
  endfunction

  // Reference model: derives expectations from the access rules with plain arithmetic.
  function automatic vec_t model(input logic wr, input logic [2:0] ctrl, input logic [31:0] a,
                                 input logic [31:0] wd, input logic [31:0] rw,
                                 input int gl, input int rl);
    vec_t v;
    int nbytes, off, idx;
    logic [31:0] shifted, val;
    bit timed_out;
    v.wr = wr; v.ctrl = ctrl; v.addr = a; v.wdata = wd; v.rword = rw;
    v.gnt_lat = gl; v.rv_lat = rl;
    if (ctrl == 3'd0 || ctrl == 3'd4) nbytes = 1;
    else if (ctrl == 3'd1 || ctrl == 3'd5) nbytes = 2;
    else nbytes = 4;
    off = int'(a % 4);
    v.exp_mis = (nbytes == 2 && (off % 2) != 0) || (nbytes == 4 && off != 0);
    if (nbytes == 1) v.exp_be = 4'(1 << off);
    else if (nbytes == 2) v.exp_be = 4'(3 << off);
    else v.exp_be = 4'hF;
    v.exp_maddr = a - 32'(off);
    if (nbytes == 1) v.exp_mwdata = (wd % 256) * 32'h0101_0101;
    else if (nbytes == 2) v.exp_mwdata = (wd % 65536) * 32'h0001_0001;
    else v.exp_mwdata = wd;
    shifted = rw >> (8 * off);
    if (nbytes == 1) begin
      val = shifted % 256;
      if (ctrl == 3'd0 && val >= 128) val = val - 32'd256;
    end else if (nbytes == 2) begin
      val = shifted % 65536;
      if (ctrl == 3'd1 && val >= 32768) val = val - 32'd65536;
    end else val = rw;
    idx = wr ? gl : gl + 1 + rl;
    timed_out = (idx >= TIMEOUT);
    v.exp_stall = timed_out ? TIMEOUT + 1 : idx + 2;
    v.exp_err   = timed_out;
    v.exp_rdata = timed_out ? 32'h0 : val;
    return v;
  endfunction

  // Runs one access from an IDLE cycle, acting as the memory, until DONE.
  task automatic apply_vec(input vec_t v, input string tag);
    int req_cnt, wait_cnt, stall_cnt, cyc;
    logic granted, gnt_prev, proto_ok, seen_req, done, we0;
    logic [3:0] be0;
    logic [31:0] a0, w0;
    req_cnt = 0; wait_cnt = 0; stall_cnt = 0; cyc = 0;
    granted = 0; gnt_prev = 0; proto_ok = 1; seen_req = 0; done = 0;
    we0 = 0; be0 = '0; a0 = '0; w0 = '0;
    @(negedge clk);
    req_valid = 1; dm_wr = v.wr; dm_ctrl = v.ctrl; addr = v.addr; wdata = v.wdata;
    mem_rdata = v.rword; mem_gnt = 0; mem_rvalid = 0;
    #1;
    check({tag, " misaligned"}, misaligned, v.exp_mis);
    if (v.exp_mis) begin
      check({tag, " mis stall"}, stall, 0);
      check({tag, " mis mem_req"}, mem_req, 0);
      check({tag, " mis rdata"}, rdata, 0);
      @(negedge clk); #1;
      check({tag, " mis mem_req next"}, mem_req, 0);
      return;
    end
    while (!done && cyc < 40) begin
      if (cyc > 0) begin
        @(negedge clk);
        mem_gnt = 0; mem_rvalid = 0;
        #1;
      end
      cyc++;
      if (!stall) begin
        done = 1;
      end else begin
        stall_cnt++;
        if (gnt_prev && mem_req) proto_ok = 0;
        gnt_prev = 0;
        if (mem_req) begin
          if (!seen_req) begin
            seen_req = 1; be0 = mem_be; a0 = mem_addr; w0 = mem_wdata; we0 = mem_we;
          end else if (mem_be !== be0 || mem_addr !== a0 || mem_wdata !== w0 || mem_we !== we0) begin
            proto_ok = 0;
          end
          if (req_cnt == v.gnt_lat) begin
            mem_gnt = 1; granted = 1; gnt_prev = 1;
          end
          req_cnt++;
        end else if (granted && !v.wr) begin
          if (wait_cnt == v.rv_lat) mem_rvalid = 1;
          wait_cnt++;
        end
      end
    end
    check({tag, " reached DONE"}, done, 1);
    check({tag, " stall cycles"}, stall_cnt, v.exp_stall);
    check({tag, " bus_err"}, bus_err, v.exp_err);
    check({tag, " mem_req in DONE"}, mem_req, 0);
    check({tag, " req seen"}, seen_req, 1);
    check({tag, " req stable/drop"}, proto_ok, 1);
    check({tag, " mem_we"}, we0, v.wr);
    check({tag, " mem_be"}, be0, v.exp_be);
    check({tag, " mem_addr"}, a0, v.exp_maddr);
    if (v.wr) check({tag, " mem_wdata"}, w0, v.exp_mwdata);
    else check({tag, " rdata"}, rdata, v.exp_rdata);
  endtask

  task automatic idle_check(input string tag);
    @(negedge clk);
    req_valid = 0; mem_gnt = 0; mem_rvalid = 0;
    #1;
    check({tag, " idle bus_err"}, bus_err, 0);
    check({tag, " idle mem_req"}, mem_req, 0);
    check({tag, " idle rdata"}, rdata, 0);
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tab[$];
    logic [2:0] pool [8];
    pool = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5, 3'd3, 3'd6, 3'd7};

    rst = 1; req_valid = 0; dm_wr = 0; dm_ctrl = 0; addr = 0; wdata = 0;
    mem_gnt = 0; mem_rvalid = 0; mem_rdata = 0;
    repeat (2) @(negedge clk);
    #1;
    check("reset stall", stall, 0);
    check("reset rdata", rdata, 0);
    check("reset bus_err", bus_err, 0);
    check("reset mem_req", mem_req, 0);
    check("reset mem_we", mem_we, 0);
    check("reset mem_be", mem_be, 0);
    check("reset mem_addr", mem_addr, 0);
    check("reset mem_wdata", mem_wdata, 0);
    check("reset misaligned", misaligned, 0);
    @(negedge clk);
    rst = 0;

    // wr ctrl addr wdata rword gnt rv | mis be maddr mwdata rdata stall err
    tab.push_back(tv(0, 3'd2, 32'h100, 0, 32'hDEADBEEF, 0, 0, 0, 4'hF, 32'h100, 0, 32'hDEADBEEF, 3, 0));
    tab.push_back(tv(0, 3'd0, 32'h103, 0, 32'h80112233, 0, 0, 0, 4'h8, 32'h100, 0, 32'hFFFFFF80, 3, 0));
    tab.push_back(tv(0, 3'd4, 32'h103, 0, 32'h80112233, 0, 0, 0, 4'h8, 32'h100, 0, 32'h00000080, 3, 0));
    tab.push_back(tv(0, 3'd5, 32'h102, 0, 32'h80112233, 0, 0, 0, 4'hC, 32'h100, 0, 32'h00008011, 3, 0));
    tab.push_back(tv(1, 3'd0, 32'h205, 32'hAB, 0, 0, 0, 0, 4'h2, 32'h204, 32'hABABABAB, 0, 2, 0));
    tab.push_back(tv(0, 3'd2, 32'h102, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0));
    tab.push_back(tv(0, 3'd1, 32'h101, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0));
    tab.push_back(tv(0, 3'd2, 32'h300, 0, 32'h12345678, 255, 0, 0, 4'hF, 32'h300, 0, 0, 17, 1));
    tab.push_back(tv(1, 3'd1, 32'h206, 32'h1234CDEF, 0, 3, 0, 0, 4'hC, 32'h204, 32'hCDEFCDEF, 0, 5, 0));
    tab.push_back(tv(0, 3'd1, 32'h102, 0, 32'h80112233, 0, 2, 0, 4'hC, 32'h100, 0, 32'hFFFF8011, 5, 0));
    tab.push_back(tv(1, 3'd3, 32'h10C, 32'h11223344, 0, 0, 0, 0, 4'hF, 32'h10C, 32'h11223344, 0, 2, 0));
    tab.push_back(tv(0, 3'd7, 32'h101, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0));
    tab.push_back(tv(0, 3'd0, 32'h101, 0, 32'h00007F00, 0, 0, 0, 4'h2, 32'h100, 0, 32'h0000007F, 3, 0));
    tab.push_back(tv(0, 3'd2, 32'h400, 0, 32'hCAFEF00D, 5, 9, 0, 4'hF, 32'h400, 0, 32'hCAFEF00D, 17, 0));
    tab.push_back(tv(0, 3'd2, 32'h400, 0, 32'hCAFEF00D, 5, 10, 0, 4'hF, 32'h400, 0, 0, 17, 1));
    tab.push_back(tv(1, 3'd2, 32'h404, 32'h55AA55AA, 0, 15, 0, 0, 4'hF, 32'h404, 32'h55AA55AA, 0, 17, 0));
    tab.push_back(tv(1, 3'd2, 32'h404, 32'h55AA55AA, 0, 16, 0, 0, 4'hF, 32'h404, 32'h55AA55AA, 0, 17, 1));
    tab.push_back(tv(1, 3'd5, 32'h103, 32'h1, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0));

    for (int i = 0; i < tab.size(); i++) begin
      apply_vec(tab[i], $sformatf("vec%0d", i));
      idle_check($sformatf("vec%0d", i));
    end

    // Back-to-back: a new request is accepted in the IDLE cycle after DONE.
    apply_vec(model(0, 3'd2, 32'h600, 0, 32'h01020304, 0, 0), "b2b0");
    apply_vec(model(1, 3'd0, 32'h601, 32'h5A, 0, 1, 0), "b2b1");
    apply_vec(model(0, 3'd5, 32'h602, 0, 32'hF00D1234, 0, 1), "b2b2");
    idle_check("b2b");

    // Reset while waiting for read data; the following rvalid must be ignored.
    @(negedge clk);
    req_valid = 1; dm_wr = 0; dm_ctrl = 3'd2; addr = 32'h500; mem_rdata = 32'h0;
    @(negedge clk); #1;
    check("rstw mem_req in REQ", mem_req, 1);
    mem_gnt = 1;
    @(negedge clk);
    mem_gnt = 0; #1;
    check("rstw stall in WAIT", stall, 1);
    check("rstw mem_req in WAIT", mem_req, 0);
    rst = 1; req_valid = 0;
    @(negedge clk);
    rst = 0; #1;
    check("rstw mem_req after rst", mem_req, 0);
    check("rstw rdata after rst", rdata, 0);
    mem_rvalid = 1; mem_rdata = 32'hFFFFFFFF;
    @(negedge clk);
    mem_rvalid = 0; #1;
    check("rstw late rvalid rdata", rdata, 0);
    check("rstw late rvalid bus_err", bus_err, 0);
    check("rstw late rvalid mem_req", mem_req, 0);
    apply_vec(model(0, 3'd2, 32'h500, 0, 32'h0BADF00D, 0, 0), "rstw next");
    idle_check("rstw");

    for (int i = 0; i < 60; i++) begin
      logic wr;
      logic [2:0] c;
      logic [31:0] a;
      int gl, rl;
      wr = 1'($urandom_range(0, 1));
      c  = pool[$urandom_range(0, 7)];
      a  = $urandom;
      if ($urandom_range(0, 1) == 1) a[1:0] = 2'b00;
      gl = ($urandom_range(0, 7) == 0) ? $urandom_range(12, 19) : $urandom_range(0, 3);
      rl = ($urandom_range(0, 5) == 0) ? $urandom_range(8, 15) : $urandom_range(0, 3);
      apply_vec(model(wr, c, a, $urandom, $urandom, gl, rl), $sformatf("rnd%0d", i));
      idle_check($sformatf("rnd%0d", i));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
